// File: rtl/uart_cfg_ctrl.sv
// UART command controller: parses HDR/ADDR/DATA/CHK write frames into a config register bank.
// Optional UART_CFG_ACK_EN adds a one-cycle ack byte (06 done / 15 error) per completed frame.
module uart_cfg_ctrl #(
  parameter int unsigned NREG     = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT  = 15000,
  parameter logic [7:0]  CFG_RST  = 8'h00
) (
  input  logic                clk,
  input  logic                res,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic [3:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic [8*NREG-1:0]   cfg_flat,
  output logic                wr_strobe,
  output logic [3:0]          wr_addr,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                ack_valid,
  output logic [7:0]          ack_data
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StHunt, StAddr, StData, StChk} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      cfg_q [NREG];
  logic [7:0]      cfg_d [NREG];
  logic [7:0]      rd_data_d;
  logic            wr_strobe_d;
  logic [3:0]      wr_addr_d;
  logic            frame_err_d;
  logic [1:0]      err_code_d;
  logic [7:0]      sum;
  logic            timeout;

  assign sum     = addr_q + data_q;
  assign timeout = (state_q != StHunt) && !rx_valid && (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cfg_d       = cfg_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    rd_data_d   = 8'h00;

    // Read port sees the pre-write bank, so a same-cycle write shows up one cycle later.
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == 4'(i)) rd_data_d = cfg_q[i];
    end

    if (state_q == StHunt || rx_valid) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      StHunt: if (rx_valid && rx_data == HDR_BYTE) state_d = StAddr;
      StAddr: if (rx_valid) begin
        addr_d  = rx_data;
        state_d = StData;
      end
      StData: if (rx_valid) begin
        data_d  = rx_data;
        state_d = StChk;
      end
      StChk: if (rx_valid) begin
        state_d = StHunt;
        if (32'(addr_q) >= NREG) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else if (rx_data != sum) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end else begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q[3:0];
          for (int i = 0; i < NREG; i++) begin
            if (addr_q == 8'(i)) cfg_d[i] = data_q;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (timeout) begin
      state_d     = StHunt;
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= StHunt;
      cnt_q     <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      cfg_q     <= '{default: CFG_RST};
      rd_data   <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 4'h0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cfg_q     <= cfg_d;
      rd_data   <= rd_data_d;
      wr_strobe <= wr_strobe_d;
      wr_addr   <= wr_addr_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign cfg_flat[8*g +: 8] = cfg_q[g];
  end

`ifdef UART_CFG_ACK_EN
  // Ack aligns with wr_strobe/frame_err because it is registered from the same next-state terms.
  always_ff @(posedge clk) begin
    if (!res) begin
      ack_valid <= 1'b0;
      ack_data  <= 8'h00;
    end else begin
      ack_valid <= wr_strobe_d | frame_err_d;
      ack_data  <= wr_strobe_d ? 8'h06 : (frame_err_d ? 8'h15 : 8'h00);
    end
  end
`else
  assign ack_valid = 1'b0;
  assign ack_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl: frame-level reference model plus directed literal checks.
module tb_uart_cfg_ctrl;

  localparam int unsigned NREG = 8;
  localparam int unsigned TO   = 50;
  localparam logic [7:0]  HDR  = 8'hA5;
  localparam logic [7:0]  RSTV = 8'h00;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic [3:0]       rd_addr = 4'h0;
  logic [7:0]       rd_data;
  logic [8*NREG-1:0] cfg_flat;
  logic             wr_strobe;
  logic [3:0]       wr_addr;
  logic             frame_err;
  logic [1:0]       err_code;
  logic             ack_valid;
  logic [7:0]       ack_data;

  uart_cfg_ctrl #(
    .NREG(NREG), .HDR_BYTE(HDR), .TIMEOUT(TO), .CFG_RST(RSTV)
  ) dut (
    .clk(clk), .res(res), .rx_data(rx_data), .rx_valid(rx_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .cfg_flat(cfg_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err), .err_code(err_code), .ack_valid(ack_valid), .ack_data(ack_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is the list of bytes collected since the header.
  logic [7:0]        fq[$];
  int                idle = 0;
  logic [7:0]        cfg_m [NREG];
  logic [3:0]        rd_sel = 4'h0;

  logic [7:0]        nxt_rd = 0, exp_rd = 0;
  logic [8*NREG-1:0] nxt_cfg = 0, exp_cfg = 0;
  logic              nxt_ws = 0, exp_ws = 0;
  logic [3:0]        nxt_wa = 0, exp_wa = 0;
  logic              nxt_fe = 0, exp_fe = 0;
  logic [1:0]        nxt_ec = 0, exp_ec = 0;
  logic              nxt_av = 0, exp_av = 0;
  logic [7:0]        nxt_ad = 0, exp_ad = 0;
  bit                started = 0;

  task automatic model();
    logic [7:0] a, d, c;
    nxt_ws = 1'b0; nxt_fe = 1'b0; nxt_av = 1'b0; nxt_ad = 8'h00;
    if (!res) begin
      fq.delete();
      idle = 0;
      for (int i = 0; i < NREG; i++) cfg_m[i] = RSTV;
      nxt_rd = 8'h00; nxt_wa = 4'h0; nxt_ec = 2'd0;
    end else begin
      nxt_rd = (int'(rd_addr) < NREG) ? cfg_m[rd_addr] : 8'h00;
      if (fq.size() != 0 && !rx_valid && idle == TO - 1) begin
        fq.delete();
        idle = 0;
        nxt_fe = 1'b1; nxt_ec = 2'd3; nxt_av = 1'b1; nxt_ad = 8'h15;
      end else if (rx_valid) begin
        if (fq.size() != 0 || rx_data == HDR) begin
          fq.push_back(rx_data);
          idle = 0;
        end
        if (fq.size() == 4) begin
          a = fq[1]; d = fq[2]; c = fq[3];
          fq.delete();
          nxt_av = 1'b1;
          if (int'(a) >= NREG) begin
            nxt_fe = 1'b1; nxt_ec = 2'd2; nxt_ad = 8'h15;
          end else if (int'(c) != (int'(a) + int'(d)) % 256) begin
            nxt_fe = 1'b1; nxt_ec = 2'd1; nxt_ad = 8'h15;
          end else begin
            cfg_m[a] = d;
            nxt_ws = 1'b1; nxt_wa = a[3:0]; nxt_ad = 8'h06;
          end
        end
      end else if (fq.size() != 0) begin
        idle++;
      end
    end
`ifndef UART_CFG_ACK_EN
    nxt_av = 1'b0; nxt_ad = 8'h00;
`endif
    for (int i = 0; i < NREG; i++) nxt_cfg[8*i +: 8] = cfg_m[i];
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic r);
    res      = r;
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    rd_addr  = rd_sel;
    model();
    @(posedge clk);
    #1;
    exp_rd = nxt_rd; exp_cfg = nxt_cfg; exp_ws = nxt_ws; exp_wa = nxt_wa;
    exp_fe = nxt_fe; exp_ec = nxt_ec; exp_av = nxt_av; exp_ad = nxt_ad;
    started = 1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("rd_data", 128'(rd_data), 128'(exp_rd));
      chk("cfg_flat", 128'(cfg_flat), 128'(exp_cfg));
      chk("wr_strobe", 128'(wr_strobe), 128'(exp_ws));
      if (exp_ws) chk("wr_addr", 128'(wr_addr), 128'(exp_wa));
      chk("frame_err", 128'(frame_err), 128'(exp_fe));
      chk("err_code", 128'(err_code), 128'(exp_ec));
      chk("ack_valid", 128'(ack_valid), 128'(exp_av));
      chk("ack_data", 128'(ack_data), 128'(exp_ad));
    end
  end

  initial begin
    logic [7:0] fb [4];
    int seen;

    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk("lit_reset_rd", 128'(rd_data), 128'h0);
    chk("lit_reset_cfg", 128'(cfg_flat), 128'h0);

    // Plain write to reg 3, then read it back
    send(8'hA5); send(8'h03); send(8'h5C); send(8'h5F);
    chk("lit_wr3_strobe", 128'(wr_strobe), 128'h1);
    chk("lit_wr3_addr", 128'(wr_addr), 128'h3);
    rd_sel = 4'd3;
    idle_cycles(2);
    chk("lit_cfg3", 128'(cfg_flat[31:24]), 128'h5C);
    chk("lit_rd3", 128'(rd_data), 128'h5C);
    chk("lit_wr3_noerr", 128'(err_code), 128'h0);

    // Noise before header, wrapping checksum
    send(8'h11); send(8'h22); send(8'hA5); send(8'h01); send(8'hFF); send(8'h00);
    idle_cycles(1);
    chk("lit_cfg1_wrap", 128'(cfg_flat[15:8]), 128'hFF);

    // Checksum error
    send(8'hA5); send(8'h02); send(8'h10); send(8'h13);
    chk("lit_cks_err", 128'(frame_err), 128'h1);
    chk("lit_cks_code", 128'(err_code), 128'h1);
`ifdef UART_CFG_ACK_EN
    chk("lit_cks_ack", 128'(ack_data), 128'h15);
`endif
    idle_cycles(1);
    chk("lit_cfg2_kept", 128'(cfg_flat[23:16]), 128'h00);

    // Bad address beats checksum
    send(8'hA5); send(8'h09); send(8'h01); send(8'h0A);
    chk("lit_addr_code", 128'(err_code), 128'h2);
    chk("lit_addr_nows", 128'(wr_strobe), 128'h0);

    // Timeout measured from the 04 pulse
    send(8'hA5); send(8'h04);
    seen = 0;
    for (int k = 1; k <= TO + 5 && seen == 0; k++) begin
      idle_cycles(1);
      if (frame_err) seen = k;
    end
    chk("lit_timeout_delay", 128'(seen), 128'(TO));
    chk("lit_timeout_code", 128'(err_code), 128'h3);
    send(8'hA5); send(8'h04); send(8'h07); send(8'h0B);
    idle_cycles(1);
    chk("lit_cfg4", 128'(cfg_flat[39:32]), 128'h07);

    // Reset mid-frame
    send(8'hA5); send(8'h05);
    step(1'b0, 8'h00, 1'b0);
    chk("lit_midrst_nofe", 128'(frame_err), 128'h0);
    send(8'hA5); send(8'h05); send(8'h01); send(8'h06);
    idle_cycles(1);
    chk("lit_midrst_cfg", 128'(cfg_flat), 128'h0000_0100_0000_0000);

    // Randomized frames, noise, near-boundary gaps and resets
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        fb[0] = 8'($urandom);
        if (fb[0] == HDR) fb[0] = 8'h5A;
        rd_sel = 4'($urandom_range(0, 15));
        send(fb[0]);
      end else begin
        fb[0] = HDR;
        fb[1] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, NREG - 1));
        fb[2] = 8'($urandom);
        fb[3] = fb[1] + fb[2];
        if ($urandom_range(0, 3) == 0) fb[3] = fb[3] ^ 8'($urandom_range(1, 255));
        for (int j = 0; j < 4; j++) begin
          rd_sel = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 39) == 0) step(1'b0, 8'h00, 1'b0);
          send(fb[j]);
          if ($urandom_range(0, 24) == 0) idle_cycles(TO - 2 + $urandom_range(0, 3));
          else idle_cycles($urandom_range(0, 3));
        end
      end
    end

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
